axis_pkt_arb: RTL
=================

# axis_pkt_arb

Packet-granular round-robin arbiter that merges up to four 8-bit AXI-Stream sources into the single write port of the dual-clock packet buffer on the music slave. It grants one source at a time and holds the grant for a whole packet, from first beat to `last`. The packet length travels on `user`; the buffer latches that length on the `last` beat. The block runs entirely in the producer clock domain and sits directly in front of the buffer's write side.

## Interface
- `N_PORT`, 4: number of source ports, 2..4
- `DATA_W`, 8: data width
- `USER_W`, 16: user width; carries the packet length in beats
- `MAX_LEN`, 2048: largest legal packet length; equals the buffer depth
- `i_clk` in 1: clock
- `i_rst_n` in 1: reset, asynchronous assert, active-low
- `i_s_axis_data` in N_PORT*DATA_W: source data; port k occupies bits [k*DATA_W +: DATA_W]
- `i_s_axis_user` in N_PORT*USER_W: source packet length; must be held constant for the whole packet
- `i_s_axis_valid` in N_PORT: source valid
- `i_s_axis_last` in N_PORT: source last
- `o_s_axis_ready` out N_PORT: source ready
- `o_m_axis_data` out DATA_W: merged data
- `o_m_axis_user` out USER_W: merged length
- `o_m_axis_valid` out 1: merged valid
- `o_m_axis_last` out 1: merged last
- `i_m_axis_ready` in 1: downstream ready
- `o_grant` out N_PORT: one-hot current grant
- `o_busy` out 1: high while in XFER or DRAIN
- `o_len_err` out 1: one-cycle pulse on a length mismatch

## Operation
- FSM states: IDLE, XFER, DRAIN.
- **IDLE**
  - If any `i_s_axis_valid` is high, pick the first requesting port at or after `r_ptr+1` (mod N_PORT).
  - Register that port into `o_grant`, set `r_ptr` to the granted index, and go to XFER.
  - If no source is valid, stay in IDLE.
- **XFER**
  - `o_m_axis_*` is a combinational mux of the granted source.
  - `o_s_axis_ready[g] = i_m_axis_ready`; every other ready is 0.
  - A beat is accepted when `o_m_axis_valid && i_m_axis_ready`.
  - An accepted beat with `o_m_axis_last` set returns the FSM to IDLE and clears `o_grant`.
- Grant never changes mid-packet. A source that drops valid mid-packet stalls the output; there is no timeout.
- In IDLE and DRAIN, `o_m_axis_valid` is 0. All `o_s_axis_ready` bits are 0, except the granted port in DRAIN.
- Beat counter `r_cnt`:
  - Width is clog2(MAX_LEN)+1.
  - Cleared on grant; increments on each accepted beat.
- Length arithmetic compares `r_cnt+1` against `user` zero-extended to USER_W. `user` = 0 or `user` > MAX_LEN is treated as a length error on the first beat.
- Reset mid-packet aborts the packet immediately. Upstream must discard the partial packet; the buffer's length FIFO never sees its `last`.

## Timing
- Reset values:
  - `o_grant` = 0, `o_busy` = 0, `o_len_err` = 0, `o_m_axis_valid` = 0.
  - `o_m_axis_last` = 0, `o_m_axis_data` = 0, `o_m_axis_user` = 0, all `o_s_axis_ready` = 0.
  - `r_ptr` = N_PORT-1, so port 0 has first priority.
- Arbitration latency is one cycle: valid seen in IDLE at cycle t, first beat may transfer at cycle t+1.
- One dead cycle per packet: the cycle after `last` is IDLE.
- Throughput inside a packet is one beat per cycle when the source is valid and the downstream is ready.
- `o_len_err` is registered: it pulses the cycle after the offending beat.

## Configuration
- Macro: `AXIS_PKT_ARB_LEN_CHECK_EN`.
- **Defined:**
  - *Long packet:* if `r_cnt+1 == user` on an accepted beat whose input `last` is 0, force `o_m_axis_last` = 1 on that beat, pulse `o_len_err`, and go to DRAIN.
  - *DRAIN:* the granted ready is held at 1, beats are discarded, and the FSM returns to IDLE on the source `last`.
  - *Short packet:* if the input `last` arrives with `r_cnt+1 != user`, pass it through, pulse `o_len_err`, and overwrite `o_m_axis_user` on that beat with `r_cnt+1`, so the buffer stores the true length.
- **Undefined:**
  - No `r_cnt`, no DRAIN state, `o_len_err` tied to 0.
  - Packets end only on the source `last`; `user` passes through unmodified.

## Structure
- Shared package `axis_pkt_pkg`:
  - Constants `AXIS_DATA_W` = 8, `AXIS_USER_W` = 16, `AXIS_MAX_LEN` = 2048.
  - FSM state enum `arb_state_t` {IDLE, XFER, DRAIN}.
  - Function `rr_pick(req, ptr)`, returning a one-hot grant.
- One sub-module, `rr_pick_n`: combinational round-robin priority encoder (req, ptr → one-hot grant, index). Reused by the other schedulers in the design.

## Test plan
- **Single source:** port 0 sends a 4-beat packet with `user` = 4 and downstream ready held at 1. Require the grant one cycle after valid, data 0x10..0x13 out on consecutive cycles, last on beat 4, and `o_busy` dropping after it.
- **Round-robin fairness:** ports 0, 1 and 3 request continuously with 2-beat packets. Require grant order 0, 1, 3, 0, 1, 3, with no port served twice before the others.
- **Backpressure:** `i_m_axis_ready` toggles 1,0,1,0 during an 8-beat packet from port 2. Require no lost or duplicated beat, exactly 8 accepted beats, and the granted ready mirroring downstream ready.
- **Long packet (macro on):** `user` = 3 but the source sends 5 beats. Require output last forced on beat 3, `o_len_err` pulsing once, beats 4-5 drained with nothing on the output, then IDLE.
- **Short packet (macro on):** `user` = 6 but last comes on beat 4. Require output user = 4 on the last beat and one `o_len_err` pulse.
- **Mid-packet reset:** assert `i_rst_n` low at beat 2 of a 5-beat packet. Require all outputs at their reset values immediately, and port 0 granted first after release.

Source files
------------

// File: rtl/axis_pkt_pkg.sv
// Shared constants, FSM state type and round-robin helper for the AXI-Stream
// packet arbiter and the other schedulers built on the same priority rule.
package axis_pkt_pkg;

    localparam int AXIS_DATA_W  = 8;
    localparam int AXIS_USER_W  = 16;
    localparam int AXIS_MAX_LEN = 2048;

    // Widest port set any scheduler in this slice arbitrates over.
    localparam int ARB_MAX_PORT = 4;
    localparam int ARB_PTR_W    = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    // One-hot grant for the first requester at or after ptr+1, wrapping around.
    function automatic logic [ARB_MAX_PORT-1:0] rr_pick(
        input logic [ARB_MAX_PORT-1:0] req,
        input logic [ARB_PTR_W-1:0]    ptr
    );
        logic [ARB_MAX_PORT-1:0] gnt;
        logic [ARB_PTR_W-1:0]    j;
        gnt = '0;
        // Scan farthest-first so the nearest requester is the last one written.
        for (int i = ARB_MAX_PORT; i >= 1; i--) begin
            j = ptr + ARB_PTR_W'(i);
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
            end else begin
                gnt = gnt;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/rr_pick_n.sv
// Combinational round-robin priority encoder: request vector and last-served
// index in, one-hot grant and its index out.
module rr_pick_n
    import axis_pkt_pkg::*;
#(
    parameter int N_PORT = 4
)(
    input  logic [N_PORT-1:0]         req,
    input  logic [$clog2(N_PORT)-1:0] ptr,
    output logic [N_PORT-1:0]         grant,
    output logic [$clog2(N_PORT)-1:0] idx
);

    localparam int IDX_W = $clog2(N_PORT);

    logic [ARB_MAX_PORT-1:0] gnt_s;

    // Padded ports never request, so widening does not disturb the rotation order.
    assign gnt_s = rr_pick(ARB_MAX_PORT'(req), ARB_PTR_W'(ptr));
    assign grant = gnt_s[N_PORT-1:0];

    // Encode the one-hot grant back to a port index.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N_PORT; i++) begin
            idx = idx | ({IDX_W{grant[i]}} & IDX_W'(i));
        end
    end

endmodule

// File: rtl/axis_pkt_arb.sv
// Packet-granular round-robin merge of up to four AXI-Stream sources.
// Define AXIS_PKT_ARB_LEN_CHECK_EN to enable length checking and the DRAIN state.
module axis_pkt_arb
    import axis_pkt_pkg::*;
#(
    parameter int N_PORT  = 4,
    parameter int DATA_W  = AXIS_DATA_W,
    parameter int USER_W  = AXIS_USER_W,
    parameter int MAX_LEN = AXIS_MAX_LEN
)(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [N_PORT*DATA_W-1:0] i_s_axis_data,
    input  logic [N_PORT*USER_W-1:0] i_s_axis_user,
    input  logic [N_PORT-1:0]        i_s_axis_valid,
    input  logic [N_PORT-1:0]        i_s_axis_last,
    output logic [N_PORT-1:0]        o_s_axis_ready,
    output logic [DATA_W-1:0]        o_m_axis_data,
    output logic [USER_W-1:0]        o_m_axis_user,
    output logic                     o_m_axis_valid,
    output logic                     o_m_axis_last,
    input  logic                     i_m_axis_ready,
    output logic [N_PORT-1:0]        o_grant,
    output logic                     o_busy,
    output logic                     o_len_err
);

    localparam int IDX_W = $clog2(N_PORT);

    arb_state_t        state_r;
    arb_state_t        state_s;
    logic [N_PORT-1:0] grant_r;
    logic [N_PORT-1:0] grant_s;
    logic [IDX_W-1:0]  ptr_r;
    logic [IDX_W-1:0]  ptr_s;
    logic [N_PORT-1:0] pick_grant_s;
    logic [IDX_W-1:0]  pick_idx_s;
    logic [DATA_W-1:0] src_data_s;
    logic [USER_W-1:0] src_user_s;
    logic              src_valid_s;
    logic              src_last_s;
    logic              accept_s;
    logic              out_last_s;
    logic [USER_W-1:0] out_user_s;

    rr_pick_n #(
        .N_PORT (N_PORT)
    ) u_rr_pick (
        .req   (i_s_axis_valid),
        .ptr   (ptr_r),
        .grant (pick_grant_s),
        .idx   (pick_idx_s)
    );

    // ptr_r equals the granted index for the whole packet, so it doubles as the source select.
    assign src_data_s  = i_s_axis_data[int'(ptr_r)*DATA_W +: DATA_W];
    assign src_user_s  = i_s_axis_user[int'(ptr_r)*USER_W +: USER_W];
    assign src_valid_s = i_s_axis_valid[ptr_r];
    assign src_last_s  = i_s_axis_last[ptr_r];
    assign accept_s    = (state_r == XFER) && src_valid_s && i_m_axis_ready;

`ifdef AXIS_PKT_ARB_LEN_CHECK_EN
    localparam int               CNT_W   = $clog2(MAX_LEN) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_s;
    logic [USER_W-1:0] beat_num_s;
    logic              user_bad_s;
    logic              trunc_s;
    logic              len_err_s;
    logic              len_err_r;

    // A bad length truncates on the first beat, so the buffer only ever sees a one-beat packet.
    assign beat_num_s = USER_W'(cnt_r + CNT_ONE);
    assign user_bad_s = (src_user_s == '0) || (src_user_s > USER_W'(MAX_LEN));
    assign trunc_s    = user_bad_s || (beat_num_s == src_user_s);
    assign out_last_s = src_last_s || trunc_s;
    assign out_user_s = (out_last_s && (beat_num_s != src_user_s)) ? beat_num_s : src_user_s;
    assign len_err_s  = accept_s && out_last_s && (!src_last_s || (beat_num_s != src_user_s));
    assign o_len_err  = len_err_r;

    // Beat counter restarts for every packet.
    always_comb begin
        if (state_r == IDLE) begin
            cnt_s = '0;
        end else if (accept_s) begin
            cnt_s = cnt_r + CNT_ONE;
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Beat counter and length-error pulse registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r     <= '0;
            len_err_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_s;
            len_err_r <= len_err_s;
        end
    end
`else
    assign out_last_s = src_last_s;
    assign out_user_s = src_user_s;
    assign o_len_err  = 1'b0;
`endif

    // Next-state, grant and output steering for the arbiter FSM.
    always_comb begin
        state_s        = state_r;
        grant_s        = grant_r;
        ptr_s          = ptr_r;
        o_s_axis_ready = '0;
        o_m_axis_valid = 1'b0;
        o_m_axis_last  = 1'b0;
        o_m_axis_data  = '0;
        o_m_axis_user  = '0;
        case (state_r)
            IDLE: begin
                if (|i_s_axis_valid) begin
                    grant_s = pick_grant_s;
                    ptr_s   = pick_idx_s;
                    state_s = XFER;
                end else begin
                    state_s = IDLE;
                end
            end
            XFER: begin
                o_m_axis_valid = src_valid_s;
                o_m_axis_last  = out_last_s;
                o_m_axis_data  = src_data_s;
                o_m_axis_user  = out_user_s;
                o_s_axis_ready = grant_r & {N_PORT{i_m_axis_ready}};
                if (accept_s && out_last_s) begin
`ifdef AXIS_PKT_ARB_LEN_CHECK_EN
                    if (src_last_s) begin
                        grant_s = '0;
                        state_s = IDLE;
                    end else begin
                        state_s = DRAIN;
                    end
`else
                    grant_s = '0;
                    state_s = IDLE;
`endif
                end else begin
                    state_s = XFER;
                end
            end
`ifdef AXIS_PKT_ARB_LEN_CHECK_EN
            DRAIN: begin
                o_s_axis_ready = grant_r;
                if (src_valid_s && src_last_s) begin
                    grant_s = '0;
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
`endif
            default: begin
                grant_s = '0;
                state_s = IDLE;
            end
        endcase
    end

    // Arbiter state, grant and round-robin pointer; the pointer resets so port 0 wins first.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
            grant_r <= '0;
            ptr_r   <= IDX_W'(N_PORT - 1);
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            ptr_r   <= ptr_s;
        end
    end

    assign o_grant = grant_r;
    assign o_busy  = (state_r != IDLE);

endmodule
